game_flow_ctrl: RTL

Top-level game sequencer for the player datapath. Walks the game through title, play, death, respawn and clear phases, and gates the player's keys. Owns the save-point respawn coordinates and drives the player state updater's reset so the player reloads at the last save. Sits between the key/collision front end and the player state updater, and feeds game_state, death_cnt and blink to the renderer.

---
 rtl/game_pkg.sv | 22 ++
 rtl/tick_timer.sv | 45 ++++
 rtl/game_flow_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game flow sequencer.
package game_pkg;

  localparam int unsigned POS_W  = 10;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned TMR_W  = 8;
  localparam int unsigned RCNT_W = 4;
  localparam int unsigned ST_W   = 3;

  localparam logic [POS_W-1:0] SPAWN_X_DEF   = 10'd200;
  localparam logic [POS_W-1:0] SPAWN_Y_DEF   = 10'd556;
  localparam logic [CNT_W-1:0] DEATH_CNT_MAX = 10'd999;

  typedef enum logic [ST_W-1:0] {
    ST_TITLE   = 3'd0,
    ST_PLAY    = 3'd1,
    ST_DEAD    = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_CLEAR   = 3'd4
  } state_t;

endpackage

// File: rtl/tick_timer.sv
// Saturating frame-tick counter with a free-running blink phase divider.
module tick_timer
  import game_pkg::*;
#(
  parameter int unsigned DEATH_TICKS = 90,
  parameter int unsigned BLINK_TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic done_c,
  output logic toggle_c
);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] ph_q, ph_d;

  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (clr) begin
      cnt_d = '0;
      ph_d  = '0;
    end else if (tick) begin
      if (cnt_q != TMR_W'(DEATH_TICKS)) cnt_d = cnt_q + TMR_W'(1);
      // Blink phase keeps running after the death timer saturates.
      ph_d = (ph_q == TMR_W'(BLINK_TICKS - 1)) ? '0 : ph_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ph_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  assign done_c   = (cnt_q == TMR_W'(DEATH_TICKS));
  assign toggle_c = tick & ~clr & (ph_q == TMR_W'(BLINK_TICKS - 1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Game phase sequencer: gates player keys, owns save-point spawn and player reset.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter logic [POS_W-1:0] SPAWN_X     = SPAWN_X_DEF,
  parameter logic [POS_W-1:0] SPAWN_Y     = SPAWN_Y_DEF,
  parameter int unsigned      DEATH_TICKS = 90,
  parameter int unsigned      BLINK_TICKS = 8,
  parameter int unsigned      RST_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start_key,
  input  logic             hit_spike,
  input  logic             at_save,
  input  logic             at_goal,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  output logic             player_rst,
  output logic             input_en,
  output logic [POS_W-1:0] spawn_x,
  output logic [POS_W-1:0] spawn_y,
  output logic [ST_W-1:0]  game_state,
  output logic [CNT_W-1:0] death_cnt,
  output logic             blink,
  output logic             save_pulse
);

  state_t            state_q, state_d;
  logic              start_q, at_save_q, at_save_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              player_rst_q, player_rst_d, input_en_q, input_en_d;
  logic [POS_W-1:0]  spawn_x_q, spawn_x_d, spawn_y_q, spawn_y_d;
  logic [CNT_W-1:0]  death_cnt_q, death_cnt_d;
  logic              blink_q, blink_d, save_pulse_q, save_pulse_d;
  logic              start_edge_c, save_edge_c, death_c, timer_done_c, blink_tgl_c;

  assign start_edge_c = start_key & ~start_q;
  assign save_edge_c  = at_save & ~at_save_q;
  assign death_c      = (state_q == ST_PLAY) & hit_spike;

  tick_timer #(
    .DEATH_TICKS (DEATH_TICKS),
    .BLINK_TICKS (BLINK_TICKS)
  ) u_tick_timer (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (death_c),
    .tick     (tick & (state_q == ST_DEAD)),
    .done_c   (timer_done_c),
    .toggle_c (blink_tgl_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_TITLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TITLE:   if (start_edge_c) state_d = ST_RESPAWN;
      ST_PLAY: begin
        if (hit_spike)    state_d = ST_DEAD;
        else if (at_goal) state_d = ST_CLEAR;
      end
      ST_DEAD:    if (start_edge_c && timer_done_c) state_d = ST_RESPAWN;
      ST_RESPAWN: if (rcnt_q == RCNT_W'(RST_CYCLES - 1)) state_d = ST_PLAY;
      ST_CLEAR:   if (start_edge_c) state_d = ST_TITLE;
      default:    state_d = ST_TITLE;
    endcase
  end

  // Registered outputs are derived from the next state so they track it exactly.
  always_comb begin
    spawn_x_d    = spawn_x_q;
    spawn_y_d    = spawn_y_q;
    death_cnt_d  = death_cnt_q;
    save_pulse_d = 1'b0;
    at_save_d    = (state_q == ST_PLAY) ? at_save : at_save_q;
    rcnt_d       = (state_q == ST_RESPAWN) ? rcnt_q + RCNT_W'(1) : '0;
    player_rst_d = (state_d == ST_TITLE) || (state_d == ST_RESPAWN);
    input_en_d   = (state_d == ST_PLAY);

    if (state_d != ST_DEAD)      blink_d = 1'b1;
    else if (state_q != ST_DEAD) blink_d = 1'b0;
    else if (blink_tgl_c)        blink_d = ~blink_q;
    else                         blink_d = blink_q;

    case (state_q)
      ST_TITLE: begin
        if (start_edge_c) begin
          spawn_x_d   = SPAWN_X;
          spawn_y_d   = SPAWN_Y;
          death_cnt_d = '0;
        end
      end
      ST_PLAY: begin
        if (hit_spike) begin
          if (death_cnt_q != DEATH_CNT_MAX) death_cnt_d = death_cnt_q + CNT_W'(1);
        end else if (!at_goal && save_edge_c) begin
          spawn_x_d    = pos_x;
          spawn_y_d    = pos_y;
          save_pulse_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q      <= 1'b1;
      at_save_q    <= 1'b1;
      rcnt_q       <= '0;
      player_rst_q <= 1'b1;
      input_en_q   <= 1'b0;
      spawn_x_q    <= SPAWN_X;
      spawn_y_q    <= SPAWN_Y;
      death_cnt_q  <= '0;
      blink_q      <= 1'b1;
      save_pulse_q <= 1'b0;
    end else begin
      start_q      <= start_key;
      at_save_q    <= at_save_d;
      rcnt_q       <= rcnt_d;
      player_rst_q <= player_rst_d;
      input_en_q   <= input_en_d;
      spawn_x_q    <= spawn_x_d;
      spawn_y_q    <= spawn_y_d;
      death_cnt_q  <= death_cnt_d;
      blink_q      <= blink_d;
      save_pulse_q <= save_pulse_d;
    end
  end

  assign player_rst = player_rst_q;
  assign input_en   = input_en_q;
  assign spawn_x    = spawn_x_q;
  assign spawn_y    = spawn_y_q;
  assign game_state = ST_W'(state_q);
  assign death_cnt  = death_cnt_q;
  assign blink      = blink_q;
  assign save_pulse = save_pulse_q;

endmodule
